// File: rtl/guess_capture_pkg.sv
// Shared definitions for the up/down game: default guess geometry and the
// capture FSM state encoding used by guess_capture.
package updown_pkg;

  localparam int GUESS_WIDTH = 7;
  localparam int GUESS_MIN   = 1;
  localparam int GUESS_MAX   = 100;
  localparam int GUESS_TRIES = 7;
  localparam int GUESS_CNT_W = 4;

  typedef logic [1:0] cap_state_t;

  localparam cap_state_t ST_IDLE   = 2'd0;
  localparam cap_state_t ST_HOLD   = 2'd1;
  localparam cap_state_t ST_LOCKED = 2'd2;

  // Compared at 32 bits so that a zero lower bound does not become a constant compare.
  function automatic logic in_range_u(input logic [31:0] v,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/guess_capture_if.sv
// Valid/ready handshake carrying a captured guess from guess_capture to the comparator.
interface guess_capture_if import updown_pkg::*; #(
  parameter int WIDTH = GUESS_WIDTH
);
  logic [WIDTH-1:0] guess_number;
  logic             guess_valid;
  logic             cmp_ready;

  modport master (output guess_number, output guess_valid, input  cmp_ready);
  modport slave  (input  guess_number, input  guess_valid, output cmp_ready);
endinterface

// File: rtl/guess_capture_trigger_edge.sv
// Rising-edge detector for the synchronised guess button. The history register
// resets to 1 so a button held through reset does not count as a press.
module trigger_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_level,
  output logic o_edge
);
  logic r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_q <= 1'b1;
    else       r_q <= i_level;
  end

  assign o_edge = i_level & ~r_q;
endmodule

// File: rtl/guess_capture.sv
// Guess capture front end: one-shot capture with range check, valid/ready hand-off,
// attempt counting and lockout. Define GUESS_DUP_REJECT_EN to reject repeated guesses.
module guess_capture import updown_pkg::*; #(
  parameter int WIDTH     = GUESS_WIDTH,
  parameter int MIN_VAL   = GUESS_MIN,
  parameter int MAX_VAL   = GUESS_MAX,
  parameter int MAX_TRIES = GUESS_TRIES,
  parameter int CNT_W     = GUESS_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             guess_trigger,
  input  logic [WIDTH-1:0] user_number,
  input  logic             new_round,
  guess_capture_if.master  cmp_if,
  output logic             err_range,
  output logic             err_dup,
  output logic [CNT_W-1:0] attempts_used,
  output logic             locked
);

  localparam logic [CNT_W-1:0] TRIES_W = CNT_W'(MAX_TRIES);

  cap_state_t       r_state;
  logic [WIDTH-1:0] r_guess;
  logic             r_valid;
  logic             r_err_range;
  logic [CNT_W-1:0] r_attempts;
  logic             r_locked;

  logic             w_edge;
  logic             w_in_range;
  logic             w_dup;
  logic             w_cap_edge;
  logic             w_range_err;
  logic             w_accept;
  logic             w_handshake;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_hit_limit;

  trigger_edge u_trigger_edge (
    .clk     (clk),
    .reset   (reset),
    .i_level (guess_trigger),
    .o_edge  (w_edge)
  );

  // new_round outranks everything, so an edge in the same cycle is simply dropped.
  assign w_in_range  = in_range_u(32'(user_number), 32'(MIN_VAL), 32'(MAX_VAL));
  assign w_cap_edge  = w_edge && (r_state == ST_IDLE) && !new_round;
  assign w_range_err = w_cap_edge && !w_in_range;
  assign w_accept    = w_cap_edge && w_in_range && !w_dup;
  assign w_handshake = (r_state == ST_HOLD) && r_valid && cmp_if.cmp_ready && !new_round;

  // Saturates at all-ones so an unlimited round never wraps back to zero.
  assign w_next_cnt  = (r_attempts == '1) ? r_attempts : r_attempts + 1'b1;
  assign w_hit_limit = (MAX_TRIES != 0) && (w_next_cnt == TRIES_W);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_guess     <= '0;
      r_valid     <= 1'b0;
      r_err_range <= 1'b0;
      r_attempts  <= '0;
      r_locked    <= 1'b0;
    end else if (new_round) begin
      r_state     <= ST_IDLE;
      r_guess     <= '0;
      r_valid     <= 1'b0;
      r_err_range <= 1'b0;
      r_attempts  <= '0;
      r_locked    <= 1'b0;
    end else begin
      r_err_range <= w_range_err;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_guess <= user_number;
            r_valid <= 1'b1;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_handshake) begin
            r_valid    <= 1'b0;
            r_attempts <= w_next_cnt;
            if (w_hit_limit) begin
              r_state  <= ST_LOCKED;
              r_locked <= 1'b1;
            end else begin
              r_state  <= ST_IDLE;
            end
          end
        end
        ST_LOCKED: r_state <= ST_LOCKED;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef GUESS_DUP_REJECT_EN
  logic [WIDTH-1:0] r_last;
  logic             r_have_last;
  logic             r_err_dup;
  logic             w_dup_err;

  assign w_dup     = r_have_last && (user_number == r_last);
  assign w_dup_err = w_cap_edge && w_in_range && w_dup;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last      <= '0;
      r_have_last <= 1'b0;
      r_err_dup   <= 1'b0;
    end else if (new_round) begin
      r_last      <= '0;
      r_have_last <= 1'b0;
      r_err_dup   <= 1'b0;
    end else begin
      r_err_dup <= w_dup_err;
      if (w_accept) begin
        r_last      <= user_number;
        r_have_last <= 1'b1;
      end
    end
  end

  assign err_dup = r_err_dup;
`else
  assign w_dup   = 1'b0;
  assign err_dup = 1'b0;
`endif

  assign cmp_if.guess_number = r_guess;
  assign cmp_if.guess_valid  = r_valid;
  assign err_range           = r_err_range;
  assign attempts_used       = r_attempts;
  assign locked              = r_locked;

endmodule

// File: tb/tb_guess_capture.sv
// Self-checking bench for guess_capture: handshake data goes through a scoreboard
// queue, control outputs are compared against values derived from the stimulus.
module tb_guess_capture;

  localparam int WIDTH = 7;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             guess_trigger;
  logic [WIDTH-1:0] user_number;
  logic             new_round;
  logic             err_range;
  logic             err_dup;
  logic [CNT_W-1:0] attempts_used;
  logic             locked;

  guess_capture_if #(.WIDTH(WIDTH)) cmp_if ();

  guess_capture u_dut (
    .clk           (clk),
    .reset         (reset),
    .guess_trigger (guess_trigger),
    .user_number   (user_number),
    .new_round     (new_round),
    .cmp_if        (cmp_if),
    .err_range     (err_range),
    .err_dup       (err_dup),
    .attempts_used (attempts_used),
    .locked        (locked)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_rng    = 0;
  int unsigned n_dup    = 0;
  logic [WIDTH-1:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Mid-cycle monitor: pulses are counted, handshakes are popped from the scoreboard.
  always @(negedge clk) begin
    if (err_range === 1'b1) n_rng++;
    if (err_dup === 1'b1) n_dup++;
    if (cmp_if.guess_valid === 1'b1 && cmp_if.cmp_ready === 1'b1) begin
      if (sb_q.size() == 0) check("sb_unexpected_hs", 32'(cmp_if.guess_number), 32'hFFFF_FFFF);
      else                  check("sb_data", 32'(cmp_if.guess_number), 32'(sb_q.pop_front()));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_new_round();
    new_round = 1'b1;
    tick();
    new_round = 1'b0;
  endtask

  task automatic do_guess(input logic [WIDTH-1:0] v);
    sb_q.push_back(v);
    user_number   = v;
    guess_trigger = 1'b1;
    tick();
    check("dg_valid", 32'(cmp_if.guess_valid), 32'd1);
    guess_trigger     = 1'b0;
    cmp_if.cmp_ready  = 1'b1;
    tick();
    cmp_if.cmp_ready  = 1'b0;
  endtask

  task automatic press_ignored(input logic [WIDTH-1:0] v, input string tag);
    user_number   = v;
    guess_trigger = 1'b1;
    tick();
    check(tag, 32'(cmp_if.guess_valid), 32'd0);
    guess_trigger = 1'b0;
    tick();
  endtask

  logic [WIDTH-1:0] lock_vals [7] = '{7'd1, 7'd100, 7'd5, 7'd17, 7'd63, 7'd99, 7'd2};

  initial begin
    reset            = 1'b1;
    guess_trigger    = 1'b1;
    user_number      = '0;
    new_round        = 1'b0;
    cmp_if.cmp_ready = 1'b0;

    // 1: reset with button held
    tick(3);
    check("rst_valid",    32'(cmp_if.guess_valid),  32'd0);
    check("rst_number",   32'(cmp_if.guess_number), 32'd0);
    check("rst_attempts", 32'(attempts_used),       32'd0);
    check("rst_locked",   32'(locked),              32'd0);
    reset = 1'b0;
    tick(3);
    check("held_no_valid", 32'(cmp_if.guess_valid), 32'd0);
    check("held_no_err",   n_rng,                   32'd0);
    guess_trigger = 1'b0;
    tick();

    // 2: capture 42, ready low 3 cycles, edge during HOLD ignored
    sb_q.push_back(7'd42);
    user_number   = 7'd42;
    guess_trigger = 1'b1;
    tick();
    check("t2_valid_c1", 32'(cmp_if.guess_valid),  32'd1);
    check("t2_num_c1",   32'(cmp_if.guess_number), 32'd42);
    guess_trigger = 1'b0;
    tick();
    check("t2_valid_c2", 32'(cmp_if.guess_valid), 32'd1);
    user_number   = 7'd77;
    guess_trigger = 1'b1;
    tick();
    check("t2_valid_c3", 32'(cmp_if.guess_valid),  32'd1);
    check("t2_hold_num", 32'(cmp_if.guess_number), 32'd42);
    guess_trigger    = 1'b0;
    cmp_if.cmp_ready = 1'b1;
    tick();
    cmp_if.cmp_ready = 1'b0;
    check("t2_valid_drop", 32'(cmp_if.guess_valid), 32'd0);
    check("t2_attempts",   32'(attempts_used),      32'd1);
    tick();

    // 3: out-of-range values
    user_number   = 7'd0;
    guess_trigger = 1'b1;
    tick();
    check("t3_err0",    32'(err_range),          32'd1);
    check("t3_valid0",  32'(cmp_if.guess_valid), 32'd0);
    guess_trigger = 1'b0;
    tick();
    check("t3_err0_pulse", 32'(err_range), 32'd0);
    user_number   = 7'd101;
    guess_trigger = 1'b1;
    tick();
    check("t3_err101",   32'(err_range),          32'd1);
    check("t3_valid101", 32'(cmp_if.guess_valid), 32'd0);
    guess_trigger = 1'b0;
    tick();
    check("t3_attempts", 32'(attempts_used), 32'd1);

    // 4: lockout after seven accepted guesses (boundaries 1 and 100 included)
    pulse_new_round();
    check("t4_nr_attempts", 32'(attempts_used), 32'd0);
    for (int i = 0; i < 7; i++) begin
      do_guess(lock_vals[i]);
      check("t4_attempts", 32'(attempts_used), 32'(i + 1));
      check("t4_locked",   32'(locked),        (i == 6) ? 32'd1 : 32'd0);
    end
    press_ignored(7'd30, "t4_locked_valid");
    press_ignored(7'd0,  "t4_locked_oor_valid");
    tick(2);
    check("t4_locked_hold", 32'(cmp_if.guess_valid), 32'd0);
    check("t4_attempts_8",  32'(attempts_used),      32'd7);
    pulse_new_round();
    check("t4_unlock",     32'(locked),              32'd0);
    check("t4_clear_cnt",  32'(attempts_used),       32'd0);
    check("t4_clear_num",  32'(cmp_if.guess_number), 32'd0);

    // 5a: new_round coinciding with an edge
    user_number   = 7'd33;
    guess_trigger = 1'b1;
    new_round     = 1'b1;
    tick();
    new_round = 1'b0;
    check("t5_nr_edge_valid", 32'(cmp_if.guess_valid),  32'd0);
    check("t5_nr_edge_num",   32'(cmp_if.guess_number), 32'd0);
    guess_trigger = 1'b0;
    tick(2);
    check("t5_nr_edge_late", 32'(cmp_if.guess_valid), 32'd0);

    // 5b: new_round aborting HOLD
    user_number   = 7'd44;
    guess_trigger = 1'b1;
    tick();
    guess_trigger = 1'b0;
    check("t5_hold_valid", 32'(cmp_if.guess_valid),  32'd1);
    check("t5_hold_num",   32'(cmp_if.guess_number), 32'd44);
    pulse_new_round();
    check("t5_abort_valid", 32'(cmp_if.guess_valid),  32'd0);
    check("t5_abort_cnt",   32'(attempts_used),       32'd0);
    check("t5_abort_num",   32'(cmp_if.guess_number), 32'd0);
    tick();

    // 6: repeated guess
    do_guess(7'd50);
    check("t6_first_cnt", 32'(attempts_used), 32'd1);
`ifdef GUESS_DUP_REJECT_EN
    user_number   = 7'd50;
    guess_trigger = 1'b1;
    tick();
    check("t6_dup_pulse", 32'(err_dup),            32'd1);
    check("t6_dup_valid", 32'(cmp_if.guess_valid), 32'd0);
    guess_trigger = 1'b0;
    tick();
    check("t6_dup_cnt", 32'(attempts_used), 32'd1);
    check("t6_dup_seen", n_dup, 32'd1);
`else
    do_guess(7'd50);
    check("t6_repeat_cnt", 32'(attempts_used), 32'd2);
    check("t6_no_dup",     n_dup,              32'd0);
`endif

    tick(2);
    check("range_pulses", n_rng,       32'd2);
    check("sb_drain",     sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
